// File: rtl/cnn_pool_3x3_stream_pkg.sv
// Shared constants for the 3x3 streaming pooling engine.
// Default geometry, reciprocal scaling and counter-width helper.
package cnn_pool_3x3_stream_pkg;

   localparam int DATA_WIDTH   = 16;
   localparam int IMAGE_WIDTH  = 8;
   localparam int IMAGE_HEIGHT = 8;
   localparam int CHANNEL_NUM  = 4;
   localparam int RECIP_9      = 7282;
   localparam int RECIP_SHIFT  = 16;

   // nine samples need four guard bits in the running sum
   localparam int SUM_GUARD = 4;

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int CH_W  = cnt_w(CHANNEL_NUM);
   localparam int COL_W = cnt_w(IMAGE_WIDTH);
   localparam int ROW_W = cnt_w(IMAGE_HEIGHT);
   localparam int SUM_W = DATA_WIDTH + SUM_GUARD;

endpackage

// File: rtl/cnn_pool_3x3_reduce_core.sv
// Pipeline stages 2-3: max tree or sum/scale/round/saturate.
// Ports: i_win (nine packed samples), i_valid/i_mode_max/i_last in; o_pxl/o_valid/o_last out.
import cnn_pool_3x3_stream_pkg::*;

module pool_3x3_reduce_core #(
   parameter int DATA_WIDTH  = 16,
   parameter int RECIP_9     = 7282,
   parameter int RECIP_SHIFT = 16
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic                    i_valid,
   input  logic                    i_mode_max,
   input  logic                    i_last,
   input  logic [9*DATA_WIDTH-1:0] i_win,
   output logic [DATA_WIDTH-1:0]   o_pxl,
   output logic                    o_valid,
   output logic                    o_last
);

   localparam int SW = DATA_WIDTH + SUM_GUARD;
   localparam int PW = SW + RECIP_SHIFT + 2;

   localparam logic signed [PW-1:0] C_RECIP = PW'(RECIP_9);
   localparam logic signed [PW-1:0] C_HALF  = PW'(1) << (RECIP_SHIFT - 1);
   localparam logic signed [PW-1:0] C_HI    =
      {{(PW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [PW-1:0] C_LO    =
      {{(PW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

   logic signed [DATA_WIDTH-1:0] w_smp [9];
   logic signed [DATA_WIDTH-1:0] w_max;
   logic signed [SW-1:0]         w_sum;

   logic                         r_s2_valid;
   logic                         r_s2_mode;
   logic                         r_s2_last;
   logic signed [DATA_WIDTH-1:0] r_s2_max;
   logic signed [SW-1:0]         r_s2_sum;

   logic signed [PW-1:0]         w_ext;
   logic signed [PW-1:0]         w_prod;
   logic signed [PW-1:0]         w_q;
   logic [DATA_WIDTH-1:0]        w_avg;

   logic [DATA_WIDTH-1:0]        r_pxl;
   logic                         r_valid;
   logic                         r_last;

   always_comb begin
      w_max = $signed(i_win[DATA_WIDTH-1:0]);
      w_sum = '0;
      for (int i = 0; i < 9; i++) begin
         w_smp[i] = $signed(i_win[i*DATA_WIDTH +: DATA_WIDTH]);
         w_sum = w_sum + $signed({{SUM_GUARD{w_smp[i][DATA_WIDTH-1]}},
                                  w_smp[i]});
         if (w_smp[i] > w_max) w_max = w_smp[i];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_s2_valid <= 1'b0;
      end else begin
         r_s2_valid <= i_valid;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_valid) begin
         r_s2_mode <= i_mode_max;
         r_s2_last <= i_last;
         r_s2_max  <= w_max;
         r_s2_sum  <= w_sum;
      end
   end

   // divide by 9 as multiply by rounded reciprocal, round half up
   always_comb begin
      w_ext  = $signed({{(PW-SW){r_s2_sum[SW-1]}}, r_s2_sum});
      w_prod = w_ext * C_RECIP;
      w_q    = (w_prod + C_HALF) >>> RECIP_SHIFT;
      if (w_q > C_HI) begin
         w_avg = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end else if (w_q < C_LO) begin
         w_avg = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      end else begin
         w_avg = DATA_WIDTH'(w_q);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_pxl   <= '0;
         r_valid <= 1'b0;
         r_last  <= 1'b0;
      end else begin
         r_valid <= r_s2_valid;
         r_last  <= r_s2_valid & r_s2_last;
         if (r_s2_valid) begin
            r_pxl <= r_s2_mode ? r_s2_max : w_avg;
         end
      end
   end

   assign o_pxl   = r_pxl;
   assign o_valid = r_valid;
   assign o_last  = r_last;

endmodule

// File: rtl/cnn_pool_3x3_stream.sv
// Streaming 3x3 max/avg pooling, channel-interleaved, stride 1 or 2.
// Ports: i_valid_in/i_pxl_in/i_mode_max/i_stride2 in; o_pxl_out/o_valid_out/o_frame_done out.
import cnn_pool_3x3_stream_pkg::*;

module cnn_pool_3x3_stream #(
   parameter int DATA_WIDTH   = cnn_pool_3x3_stream_pkg::DATA_WIDTH,
   parameter int IMAGE_WIDTH  = cnn_pool_3x3_stream_pkg::IMAGE_WIDTH,
   parameter int IMAGE_HEIGHT = cnn_pool_3x3_stream_pkg::IMAGE_HEIGHT,
   parameter int CHANNEL_NUM  = cnn_pool_3x3_stream_pkg::CHANNEL_NUM,
   parameter int RECIP_9      = cnn_pool_3x3_stream_pkg::RECIP_9,
   parameter int RECIP_SHIFT  = cnn_pool_3x3_stream_pkg::RECIP_SHIFT
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_valid_in,
   input  logic [DATA_WIDTH-1:0] i_pxl_in,
   input  logic                  i_mode_max,
   input  logic                  i_stride2,
   output logic [DATA_WIDTH-1:0] o_pxl_out,
   output logic                  o_valid_out,
   output logic                  o_frame_done
);

   localparam int LCH_W  = cnt_w(CHANNEL_NUM);
   localparam int LCOL_W = cnt_w(IMAGE_WIDTH);
   localparam int LROW_W = cnt_w(IMAGE_HEIGHT);
   localparam int DEPTH  = IMAGE_WIDTH * CHANNEL_NUM;
   localparam int ADR_W  = cnt_w(DEPTH);
   localparam int TAPS   = 2 * CHANNEL_NUM;

   localparam logic [LCH_W-1:0]  CH_LAST   = LCH_W'(CHANNEL_NUM - 1);
   localparam logic [LCOL_W-1:0] COL_LAST  = LCOL_W'(IMAGE_WIDTH - 1);
   localparam logic [LROW_W-1:0] ROW_LAST  = LROW_W'(IMAGE_HEIGHT - 1);
   // last even position: final stride-2 window
   localparam logic [LCOL_W-1:0] COL_LAST2 =
      LCOL_W'(((IMAGE_WIDTH - 1) / 2) * 2);
   localparam logic [LROW_W-1:0] ROW_LAST2 =
      LROW_W'(((IMAGE_HEIGHT - 1) / 2) * 2);

   logic [LCH_W-1:0]       r_ch;
   logic [LCOL_W-1:0]      r_col;
   logic [LROW_W-1:0]      r_row;
   logic [ADR_W-1:0]       r_addr;
   logic                   r_mode_max;
   logic                   r_stride2;

   logic [DATA_WIDTH-1:0]  r_lb1 [DEPTH];
   logic [DATA_WIDTH-1:0]  r_lb2 [DEPTH];
   logic [DATA_WIDTH-1:0]  r_tap [3][TAPS];

   logic                   r_s1_valid;
   logic                   r_s1_mode;
   logic                   r_s1_last;
   logic [9*DATA_WIDTH-1:0] r_s1_win;

   logic                   w_ch_wrap;
   logic                   w_col_wrap;
   logic                   w_start;
   logic                   w_even;
   logic                   w_emit;
   logic                   w_last;
   logic [DATA_WIDTH-1:0]  w_lb1;
   logic [DATA_WIDTH-1:0]  w_lb2;
   logic [DATA_WIDTH-1:0]  w_head [3];
   logic [9*DATA_WIDTH-1:0] w_win;

   assign w_ch_wrap  = (r_ch == CH_LAST);
   assign w_col_wrap = w_ch_wrap && (r_col == COL_LAST);
   assign w_start    = i_valid_in && (r_ch == '0)
                       && (r_col == '0) && (r_row == '0);

   // old contents: rows r-1 and r-2 at this column/channel
   assign w_lb1 = r_lb1[r_addr];
   assign w_lb2 = r_lb2[r_addr];

   always_comb begin
      w_head[0] = w_lb2;
      w_head[1] = w_lb1;
      w_head[2] = i_pxl_in;
   end

   // per row: current column, col-1 and col-2 of the same channel
   always_comb begin
      w_win = '0;
      for (int k = 0; k < 3; k++) begin
         w_win[(3*k)*DATA_WIDTH +: DATA_WIDTH]   = w_head[k];
         w_win[(3*k+1)*DATA_WIDTH +: DATA_WIDTH] = r_tap[k][CHANNEL_NUM-1];
         w_win[(3*k+2)*DATA_WIDTH +: DATA_WIDTH] = r_tap[k][TAPS-1];
      end
   end

   assign w_even = ~r_row[0] & ~r_col[0];
   assign w_emit = i_valid_in
                   && (r_row >= LROW_W'(2))
                   && (r_col >= LCOL_W'(2))
                   && (!r_stride2 || w_even);
   assign w_last = w_ch_wrap
                   && (r_col == (r_stride2 ? COL_LAST2 : COL_LAST))
                   && (r_row == (r_stride2 ? ROW_LAST2 : ROW_LAST));

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_ch       <= '0;
         r_col      <= '0;
         r_row      <= '0;
         r_addr     <= '0;
         r_mode_max <= 1'b0;
         r_stride2  <= 1'b0;
      end else if (i_valid_in) begin
         if (w_start) begin
            r_mode_max <= i_mode_max;
            r_stride2  <= i_stride2;
         end
         r_addr <= w_col_wrap ? '0 : r_addr + 1'b1;
         if (!w_ch_wrap) begin
            r_ch <= r_ch + 1'b1;
         end else begin
            r_ch <= '0;
            if (!w_col_wrap) begin
               r_col <= r_col + 1'b1;
            end else begin
               r_col <= '0;
               r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_valid_in) begin
         r_lb1[r_addr] <= i_pxl_in;
         r_lb2[r_addr] <= w_lb1;
         for (int k = 0; k < 3; k++) begin
            r_tap[k][0] <= w_head[k];
            for (int i = 1; i < TAPS; i++) begin
               r_tap[k][i] <= r_tap[k][i-1];
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_s1_valid <= 1'b0;
      end else begin
         r_s1_valid <= w_emit;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_emit) begin
         r_s1_win  <= w_win;
         r_s1_mode <= r_mode_max;
         r_s1_last <= w_last;
      end
   end

   pool_3x3_reduce_core #(
      .DATA_WIDTH  (DATA_WIDTH),
      .RECIP_9     (RECIP_9),
      .RECIP_SHIFT (RECIP_SHIFT)
   ) u_core (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_valid    (r_s1_valid),
      .i_mode_max (r_s1_mode),
      .i_last     (r_s1_last),
      .i_win      (r_s1_win),
      .o_pxl      (o_pxl_out),
      .o_valid    (o_valid_out),
      .o_last     (o_frame_done)
   );

endmodule

// File: tb/tb_cnn_pool_3x3_stream.sv
// Directed bench for cnn_pool_3x3_stream: 3x3x1 and 8x8x4 instances.
// Expected windows, values and due cycles are queued per instance.
module tb_cnn_pool_3x3_stream;

   typedef struct {
      int   val;
      logic last;
      int   due;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst;
   logic               vs;
   logic               vl;
   logic signed [15:0] d;
   logic               mm;
   logic               s2;

   logic signed [15:0] po_s;
   logic signed [15:0] po_l;
   logic               vo_s;
   logic               vo_l;
   logic               fd_s;
   logic               fd_l;

   exp_t q [2][$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   int   n_out_l = 0;

   cnn_pool_3x3_stream #(
      .DATA_WIDTH(16), .IMAGE_WIDTH(3), .IMAGE_HEIGHT(3),
      .CHANNEL_NUM(1), .RECIP_9(7282), .RECIP_SHIFT(16)
   ) u_s (
      .i_clk(clk), .i_reset(rst), .i_valid_in(vs), .i_pxl_in(d),
      .i_mode_max(mm), .i_stride2(s2), .o_pxl_out(po_s),
      .o_valid_out(vo_s), .o_frame_done(fd_s)
   );

   cnn_pool_3x3_stream #(
      .DATA_WIDTH(16), .IMAGE_WIDTH(8), .IMAGE_HEIGHT(8),
      .CHANNEL_NUM(4), .RECIP_9(7282), .RECIP_SHIFT(16)
   ) u_l (
      .i_clk(clk), .i_reset(rst), .i_valid_in(vl), .i_pxl_in(d),
      .i_mode_max(mm), .i_stride2(s2), .o_pxl_out(po_l),
      .o_valid_out(vo_l), .o_frame_done(fd_l)
   );

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic mon(input int k, input logic v, input logic f,
                      input logic signed [15:0] p);
      exp_t e;
      if (v === 1'b1) begin
         if (k == 1) n_out_l++;
         if (q[k].size() == 0) begin
            chk($sformatf("unexpected_valid%0d", k), 32'(v), 0);
         end else begin
            e = q[k].pop_front();
            chk($sformatf("pxl%0d", k), p, e.val);
            chk($sformatf("frame_done%0d", k), 32'(f), 32'(e.last));
            chk($sformatf("latency%0d", k), cyc, e.due);
         end
      end else begin
         chk($sformatf("valid_x%0d", k), 32'(v), 0);
         chk($sformatf("idle_done%0d", k), 32'(f), 0);
      end
   endtask

   task automatic step(input logic r, input logic a, input logic b,
                       input logic signed [15:0] x, input logic m,
                       input logic t);
      @(posedge clk);
      #1;
      rst = r; vs = a; vl = b; d = x; mm = m; s2 = t;
      cyc++;
      @(negedge clk);
      mon(0, vo_s, fd_s, po_s);
      mon(1, vo_l, fd_l, po_l);
   endtask

   task automatic frame_s(input int v0, input int inc, input logic m,
                          input int ev);
      for (int i = 0; i < 9; i++) begin
         step(1'b0, 1'b1, 1'b0, 16'(v0 + inc * i), m, 1'b0);
      end
      q[0].push_back('{ev, 1'b1, cyc + 3});
      repeat (4) step(1'b0, 1'b0, 1'b0, 16'sd0, m, 1'b0);
   endtask

   // kind 0: value 10*ch+row, kind 1: ramp row*64+col*4+ch
   task automatic frame_l(input int kind, input logic m, input logic t,
                          input bit gaps, input int rst_at);
      int   idx;
      int   x;
      int   ev;
      logic lst;
      logic mi;
      logic ti;
      idx = 0;
      for (int row = 0; row < 8; row++) begin
         for (int col = 0; col < 8; col++) begin
            for (int ch = 0; ch < 4; ch++) begin
               x = (kind == 0) ? 10 * ch + row : row * 64 + col * 4 + ch;
               if (gaps) begin
                  repeat ($urandom_range(0, 2))
                     step(1'b0, 1'b0, 1'b0, 16'($urandom), ~m, ~t);
               end
               if (idx == rst_at) begin
                  step(1'b1, 1'b0, 1'b0, 16'sd0, m, t);
                  while (q[1].size() > 0 && q[1][$].due > cyc)
                     void'(q[1].pop_back());
                  return;
               end
               mi = (idx % 2 == 1) ? ~m : m;
               ti = (idx % 2 == 1) ? ~t : t;
               step(1'b0, 1'b0, 1'b1, 16'(x), mi, ti);
               if (row >= 2 && col >= 2 &&
                   (!t || (row % 2 == 0 && col % 2 == 0))) begin
                  ev  = (kind == 0) ? 10 * ch + row - 1 : x;
                  lst = (ch == 3) && (row == (t ? 6 : 7))
                        && (col == (t ? 6 : 7));
                  q[1].push_back('{ev, lst, cyc + 3});
               end
               idx++;
            end
         end
      end
   endtask

   task automatic drain();
      repeat (8) step(1'b0, 1'b0, 1'b0, 16'sd0, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b1; vs = 1'b0; vl = 1'b0; d = '0; mm = 1'b0; s2 = 1'b0;
      step(1'b1, 1'b0, 1'b0, 16'sd0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 16'sd0, 1'b0, 1'b0);
      chk("rst_pxl_s", po_s, 0);
      chk("rst_vo_s", 32'(vo_s), 0);
      chk("rst_fd_s", 32'(fd_s), 0);
      chk("rst_pxl_l", po_l, 0);
      chk("rst_vo_l", 32'(vo_l), 0);
      chk("rst_fd_l", 32'(fd_l), 0);

      frame_s(9, 0, 1'b0, 9);
      chk("hold_s", po_s, 9);
      frame_s(-9, 0, 1'b0, -9);
      frame_s(0, 1, 1'b1, 8);
      frame_s(32767, 0, 1'b0, 32767);
      frame_s(-32768, 0, 1'b0, -32768);

      n_out_l = 0;
      frame_l(0, 1'b0, 1'b0, 1'b0, -1);
      frame_l(1, 1'b1, 1'b1, 1'b0, -1);
      drain();
      chk("count_b2b", n_out_l, 144 + 36);

      n_out_l = 0;
      frame_l(0, 1'b0, 1'b0, 1'b1, -1);
      drain();
      chk("count_gaps", n_out_l, 144);

      frame_l(1, 1'b1, 1'b0, 1'b0, 4 * 32 + 3 * 4 + 1);
      step(1'b0, 1'b0, 1'b0, 16'sd0, 1'b0, 1'b0);
      chk("abort_vo", 32'(vo_l), 0);
      repeat (5) step(1'b0, 1'b0, 1'b0, 16'sd0, 1'b0, 1'b0);

      n_out_l = 0;
      frame_l(1, 1'b1, 1'b0, 1'b0, -1);
      drain();
      chk("count_clean", n_out_l, 144);

      chk("left_s", q[0].size(), 0);
      chk("left_l", q[1].size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
